// File: rtl/dp_mem_port_arbiter.sv
// dp_mem_port_arbiter: round-robin sharing of one DP_MEM port among N_REQ
// requesters, one transaction outstanding, with a watchdog that aborts
// accesses the memory never accepts.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction; candidate offered req_ready combinationally
// ISSUE | mem_valid high, waiting for mem_ready; watchdog running
// WAIT  | read accepted, counting down the read latency
// RESP  | one-cycle rsp_valid pulse to the owner; ptr advances
module dp_mem_port_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0]           req_op,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic                       mem_op,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int GID_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int LAT_W = $clog2(RD_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state;
    logic [GID_W-1:0] ptr;
    logic [GID_W-1:0] cand;
    logic             cand_found;
    logic [GID_W:0]   scan_sum;
    logic [WD_W-1:0]  wd_cnt;
    logic [LAT_W-1:0] lat_cnt;

    // Round-robin scan: first valid requester at or after ptr, wrapping.
    always_comb begin
        cand       = '0;
        cand_found = 1'b0;
        scan_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, ptr} + (GID_W+1)'(k);
            if (scan_sum >= (GID_W+1)'(N_REQ))
                scan_sum = scan_sum - (GID_W+1)'(N_REQ);
            if (!cand_found && req_valid[scan_sum[GID_W-1:0]]) begin
                cand_found = 1'b1;
                cand       = scan_sum[GID_W-1:0];
            end
        end
    end

    // Offer the grant only while idle; held off during reset so no
    // request is consumed by a cycle that the reset is about to discard.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && cand_found && !rst)
            req_ready[cand] = 1'b1;
    end

    // Transaction FSM with registered memory and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            wd_cnt    <= '0;
            lat_cnt   <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_valid <= 1'b0;
            mem_op    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (cand_found) begin
                        mem_op    <= req_op[cand];
                        mem_addr  <= req_addr[int'(cand)*ADDR_W +: ADDR_W];
                        mem_wdata <= req_wdata[int'(cand)*DATA_W +: DATA_W];
                        grant_id  <= cand;
                        wd_cnt    <= '0;
                        mem_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (mem_op) begin
                            rsp_valid[grant_id] <= 1'b1;
                            rsp_rdata           <= '0;
                            rsp_err             <= 1'b0;
                            state               <= S_RESP;
                        end else begin
                            lat_cnt <= LAT_W'(RD_LAT - 1);
                            state   <= S_WAIT;
                        end
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        // Memory never accepted: abort with an error response.
                        mem_valid           <= 1'b0;
                        rsp_valid[grant_id] <= 1'b1;
                        rsp_rdata           <= '0;
                        rsp_err             <= 1'b1;
                        state               <= S_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        rsp_valid[grant_id] <= 1'b1;
                        rsp_rdata           <= mem_rdata;
                        rsp_err             <= 1'b0;
                        state               <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    ptr     <= (grant_id == GID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                    rsp_err <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    mem_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
